// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling default,
// and the baud_select-to-divisor table used by both transmitter and receiver.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEFAULT = 16;
  localparam int unsigned SEL_W              = 3;
  localparam int unsigned DATA_W             = 8;
  localparam int unsigned DIV_W              = 10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  // Result of one completed frame as presented on the receiver outputs.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              perror;
    logic              ferror;
  } rx_result_t;

  // System clock cycles per oversampling tick, 16 MHz clock, 16 ticks per bit.
  function automatic logic [DIV_W-1:0] baud_divisor(input logic [SEL_W-1:0] sel);
    logic [DIV_W-1:0] div;
    div = DIV_W'(9);
    case (sel)
      3'd0: div = DIV_W'(833);  // 1200
      3'd1: div = DIV_W'(417);  // 2400
      3'd2: div = DIV_W'(208);  // 4800
      3'd3: div = DIV_W'(104);  // 9600
      3'd4: div = DIV_W'(52);   // 19200
      3'd5: div = DIV_W'(26);   // 38400
      3'd6: div = DIV_W'(17);   // 57600
      3'd7: div = DIV_W'(9);    // 115200
      default: div = DIV_W'(9);
    endcase
    return div;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Receiver-side UART signal bundle: line, control and frame result outputs.
interface uart_receiver_if;
  import uart_pkg::*;

  logic [SEL_W-1:0]  baud_select;
  logic              Rx_EN;
  logic              RxD;
  logic [DATA_W-1:0] Rx_DATA;
  logic              Rx_VALID;
  logic              Rx_PERROR;
  logic              Rx_FERROR;

  modport master (
    output baud_select, Rx_EN, RxD,
    input  Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR
  );

  modport slave (
    input  baud_select, Rx_EN, RxD,
    output Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR
  );

endinterface

// File: rtl/baud_controller.sv
// Oversampling tick generator: one-clk sample_ENABLE pulse every
// baud_divisor(baud_select) clocks, used as a clock enable downstream.
module baud_controller
  import uart_pkg::*;
(
  input  logic             reset,
  input  logic             clk,
  input  logic [SEL_W-1:0] baud_select,
  output logic             sample_ENABLE
);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_last_c;

  assign div_last_c = baud_divisor(baud_select) - DIV_W'(1);

  // >= rather than == so a smaller divisor selected in idle wraps at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt       <= '0;
      sample_ENABLE <= 1'b0;
    end else if (div_cnt >= div_last_c) begin
      div_cnt       <= '0;
      sample_ENABLE <= 1'b1;
    end else begin
      div_cnt       <= div_cnt + DIV_W'(1);
      sample_ENABLE <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: start, 8 data bits LSB first, even parity, stop.
// Define UART_RX_MAJORITY_EN to take each bit as the 2-of-3 vote of ticks 7, 8, 9.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  uart_receiver_if.slave  bus
);

  localparam int unsigned HALF  = OVERSAMPLE / 2;
  localparam int unsigned CNT_W = $clog2(OVERSAMPLE + 1);
  localparam int unsigned IDX_W = $clog2(DATA_W);

  logic              sample_enable;
  logic              rxd_meta;
  logic              rxd_s;
  rx_state_t         state;
  rx_state_t         state_nxt;
  logic [CNT_W-1:0]  tick_cnt;
  logic [CNT_W-1:0]  tick_cnt_nxt;
  logic [IDX_W-1:0]  bit_idx;
  logic [IDX_W-1:0]  bit_idx_nxt;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_nxt;
  logic              parity_bit;
  logic              parity_nxt;
  rx_result_t        result_q;
  rx_result_t        result_nxt;
  logic              valid_q;
  logic              valid_nxt;
  logic              decide_c;
  logic              bit_val_c;

  baud_controller u_baud (
    .reset         (reset),
    .clk           (clk),
    .baud_select   (bus.baud_select),
    .sample_ENABLE (sample_enable)
  );

  // Two-flop synchronizer; idles high like the line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= bus.RxD;
      rxd_s    <= rxd_meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] early_samp;

  // Line value at ticks 7 and 8; the vote completes with tick 9
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      early_samp <= 2'b11;
    end else if (sample_enable && tick_cnt == CNT_W'(HALF - 2)) begin
      early_samp[0] <= rxd_s;
    end else if (sample_enable && tick_cnt == CNT_W'(HALF - 1)) begin
      early_samp[1] <= rxd_s;
    end
  end

  assign decide_c  = sample_enable && (tick_cnt == CNT_W'(HALF));
  assign bit_val_c = majority3(early_samp[0], early_samp[1], rxd_s);
`else
  assign decide_c  = sample_enable && (tick_cnt == CNT_W'(HALF - 1));
  assign bit_val_c = rxd_s;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // tick_cnt holds the number of ticks already seen in the current bit (1..OVERSAMPLE)
  always_comb begin
    state_nxt    = state;
    tick_cnt_nxt = tick_cnt;
    bit_idx_nxt  = bit_idx;
    shift_nxt    = shift_reg;
    parity_nxt   = parity_bit;
    result_nxt   = result_q;
    valid_nxt    = 1'b0;

    if (!bus.Rx_EN) begin
      state_nxt    = IDLE;
      tick_cnt_nxt = '0;
    end else if (sample_enable) begin
      if (state != IDLE) begin
        tick_cnt_nxt = (tick_cnt == CNT_W'(OVERSAMPLE)) ? CNT_W'(1) : tick_cnt + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (!rxd_s) begin
            state_nxt    = START;
            tick_cnt_nxt = CNT_W'(1);
            bit_idx_nxt  = '0;
          end
        end
        START: begin
          if (decide_c) state_nxt = bit_val_c ? IDLE : DATA;
        end
        DATA: begin
          if (decide_c) begin
            shift_nxt[bit_idx] = bit_val_c;
            bit_idx_nxt        = bit_idx + IDX_W'(1);
            if (bit_idx == IDX_W'(DATA_W - 1)) state_nxt = PARITY;
          end
        end
        PARITY: begin
          if (decide_c) begin
            parity_nxt = bit_val_c;
            state_nxt  = STOP;
          end
        end
        STOP: begin
          // Back to IDLE straight after the sample so an immediate start bit is caught
          if (decide_c) begin
            result_nxt.data   = shift_reg;
            result_nxt.perror = parity_bit ^ (^shift_reg);
            result_nxt.ferror = ~bit_val_c;
            valid_nxt         = ~(parity_bit ^ (^shift_reg)) & bit_val_c;
            state_nxt         = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      result_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      tick_cnt   <= tick_cnt_nxt;
      bit_idx    <= bit_idx_nxt;
      shift_reg  <= shift_nxt;
      parity_bit <= parity_nxt;
      result_q   <= result_nxt;
      valid_q    <= valid_nxt;
    end
  end

  assign bus.Rx_DATA   = result_q.data;
  assign bus.Rx_PERROR = result_q.perror;
  assign bus.Rx_FERROR = result_q.ferror;
  assign bus.Rx_VALID  = valid_q;

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter: OVERSAMPLE, 16, sample_ENABLE ticks per bit period; mid-bit sample at tick OVERSAMPLE/2.
REQ-002 Port: clk  input  1  system clock; all state changes on posedge clk.
REQ-003 Port: reset  input  1  reset, asynchronous, active-high.
REQ-004 Port: baud_select  input  3  baud rate code, same encoding as the transmitter side.
REQ-005 Port: Rx_EN  input  1  receiver enable; 0 holds the FSM in IDLE.
REQ-006 Port: RxD  input  1  serial line, idle high.
REQ-007 Port: Rx_DATA  output  8  last received byte.
REQ-008 Port: Rx_VALID  output  1  one-clk pulse per error-free frame.
REQ-009 Port: Rx_PERROR  output  1  parity error of last frame.
REQ-010 Port: Rx_FERROR  output  1  framing (stop bit) error of last frame.

Function
REQ-011 Frame SHALL be: start(0), D0..D7 LSB first, parity, stop(1); parity even, i.e. expected parity bit = XOR of D7..D0.
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; the FSM advances only on clk edges where sample_ENABLE=1.
REQ-013 IDLE->START on the first tick with RxD=0; the tick counter is cleared to 1 at this point.
REQ-014 START: at tick 8, RxD=1 -> false start, return to IDLE with no output change; RxD=0 -> DATA with the tick counter restarted.
REQ-015 DATA: sample at tick 8 of each bit into shift register bit index 0..7; after the 8th bit go to PARITY.
REQ-016 PARITY: sample at tick 8, then go to STOP.
REQ-017 STOP: sample at tick 8, then go directly to IDLE. The half bit remaining is not waited out, so a back-to-back start bit is caught.
REQ-018 On the STOP sample, in the same clk: Rx_DATA <= shift register; Rx_PERROR <= (parity mismatch); Rx_FERROR <= (stop sample == 0).
REQ-019 Rx_VALID SHALL pulse high for exactly one clk on the STOP sample only if both error conditions are 0; otherwise it stays 0.
REQ-020 Rx_PERROR/Rx_FERROR SHALL hold until the next STOP sample or reset; a false start does not clear them.
REQ-021 Rx_EN=0 SHALL force the FSM to IDLE on the next clk and abort any frame with no output update; Rx_DATA and the error flags hold.
REQ-022 A baud_select change mid-frame SHALL NOT be supported; bench changes it only in IDLE.

Reset
REQ-023 Reset SHALL asynchronously force: FSM=IDLE, tick counter=0, shift register=0, Rx_DATA=8'h00, Rx_VALID=0, Rx_PERROR=0, Rx_FERROR=0.
REQ-024 Reset mid-frame SHALL discard the frame; the first start bit after release is received normally.

Configuration
REQ-025 Macro UART_RX_MAJORITY_EN defined: each bit value (start, data, parity, stop) = majority of RxD at ticks 7, 8, 9; the decision is taken at tick 9.
REQ-026 Macro UART_RX_MAJORITY_EN undefined: single sample at tick 8, per REQ-014..REQ-018.

Structure
REQ-027 Shared package uart_pkg SHALL hold the state encoding constants, OVERSAMPLE default, and the baud_select-to-divisor table shared with the transmitter.
REQ-028 Tick generation SHALL use one sub-module, baud_controller (ports reset, clk, baud_select, sample_ENABLE), used as a clock enable, never as a clock.

Verification
REQ-029 baud_select=3'b111, frame 0xA5 with parity 0 and stop 1 -> Rx_DATA=8'hA5, Rx_VALID one-clk pulse, PERROR=0, FERROR=0.
REQ-030 Frame 0x01 with parity bit 0 -> Rx_DATA=8'h01, Rx_PERROR=1, Rx_VALID stays 0.
REQ-031 Frame 0x3C with parity 0 and stop bit 0 -> Rx_FERROR=1, Rx_PERROR=0, no Rx_VALID.
REQ-032 RxD low for 4 ticks then high -> FSM back to IDLE, no output change; a following valid 0x5A frame yields Rx_DATA=8'h5A.
REQ-033 Reset during D3 of frame 0xFF, then frame 0x81 -> all outputs 0 after reset; then Rx_DATA=8'h81 with Rx_VALID pulse.
REQ-034 With UART_RX_MAJORITY_EN: frame 0x00 with a 1-tick high glitch at tick 8 of D2 -> Rx_DATA=8'h00 and Rx_VALID. Without the macro: Rx_DATA=8'h04 and Rx_PERROR=1.
